// File: rtl/fetch_if.sv
// fetch_if: instruction-memory and decoder handshake signals of the fetch unit
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [5:0]  dec_opcode;
  logic [5:0]  dec_funct;
  logic [15:0] fetch_cnt;
  modport master (
    output imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_opcode, dec_funct, fetch_cnt,
    input  imem_ack, imem_rdata, redirect, redirect_pc, dec_ready
  );
  modport slave (
    input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_opcode, dec_funct, fetch_cnt,
    output imem_ack, imem_rdata, redirect, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-entry instruction fetch with redirect and decoder handshake
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input logic     clk,
  input logic     rst_n,
  fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic        capture, accept;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == IDLE || bus.redirect) ? REQ :
               (state == REQ && bus.imem_ack)  ? HOLD :
               (state == HOLD && bus.dec_ready) ? REQ : state;
  always_comb begin
    bus.imem_req  = state == REQ;
    bus.dec_valid = state == HOLD;
    bus.imem_addr = pc;
    capture       = state == REQ && bus.imem_ack && !bus.redirect;
    accept        = state == HOLD && bus.dec_ready;
    pc_nx         = bus.redirect ? (bus.redirect_pc & 32'hFFFF_FFFC) : capture ? pc + 32'd4 : pc;
  end
  // a redirect coinciding with the decoder accept still counts that handshake
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc             <= RESET_PC & 32'hFFFF_FFFC;
      bus.dec_instr  <= '0;
      bus.dec_pc     <= '0;
      bus.dec_opcode <= '0;
      bus.dec_funct  <= '0;
      bus.fetch_cnt  <= '0;
    end else begin
      pc <= pc_nx;
      if (capture) begin
        bus.dec_instr  <= bus.imem_rdata;
        bus.dec_pc     <= pc;
        bus.dec_opcode <= bus.imem_rdata[31:26];
        bus.dec_funct  <= bus.imem_rdata[5:0];
      end
      if (accept) bus.fetch_cnt <= bus.fetch_cnt + 16'd1;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven scoreboard bench for fetch_unit
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fetch_if bus();
  fetch_if bus2();
  fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  typedef struct {
    logic [31:0] rdata;
    int          ack_wait;
    int          ready_wait;
    logic [5:0]  op;
    logic [5:0]  fn;
  } vec_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  fn;
  } exp_t;
  vec_t        vecs[5];
  exp_t        sb[$];
  exp_t        e;
  logic [31:0] mpc;
  logic [15:0] mcnt;
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    vecs = '{
      '{32'h8C22_0010, 0, 0, 6'h23, 6'h10},
      '{32'h0123_4567, 3, 0, 6'h00, 6'h27},
      '{32'hAC41_002A, 0, 5, 6'h2B, 6'h2A},
      '{32'hFFFF_FFFF, 1, 2, 6'h3F, 6'h3F},
      '{32'h0000_0000, 2, 1, 6'h00, 6'h00}
    };
    bus.imem_ack = 0; bus.imem_rdata = 0; bus.redirect = 0; bus.redirect_pc = 0; bus.dec_ready = 0;
    bus2.imem_ack = 1; bus2.imem_rdata = 32'h1234_5678; bus2.redirect = 0; bus2.redirect_pc = 0; bus2.dec_ready = 1;
    #12;
    chk("rst_req", {31'd0, bus.imem_req}, 0);
    chk("rst_addr", bus.imem_addr, 32'h0000_3000);
    chk("rst_valid", {31'd0, bus.dec_valid}, 0);
    chk("rst_instr", bus.dec_instr, 0);
    chk("rst_pc", bus.dec_pc, 0);
    chk("rst_op_fn", {20'd0, bus.dec_opcode, bus.dec_funct}, 0);
    chk("rst_cnt", {16'd0, bus.fetch_cnt}, 0);
    bus.imem_ack = 1; bus.imem_rdata = 32'h2008_0005; bus.dec_ready = 1;
    @(negedge clk) rst_n = 1;
    step;
    chk("c1_req", {31'd0, bus.imem_req}, 1);
    chk("c1_addr", bus.imem_addr, 32'h0000_3000);
    chk("wrap_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
    step;
    chk("c2_valid", {31'd0, bus.dec_valid}, 1);
    chk("c2_opcode", {26'd0, bus.dec_opcode}, 32'h08);
    chk("c2_funct", {26'd0, bus.dec_funct}, 32'h05);
    chk("c2_pc", bus.dec_pc, 32'h0000_3000);
    chk("c2_instr", bus.dec_instr, 32'h2008_0005);
    step;
    chk("c3_req", {31'd0, bus.imem_req}, 1);
    chk("c3_addr", bus.imem_addr, 32'h0000_3004);
    chk("c3_cnt", {16'd0, bus.fetch_cnt}, 1);
    chk("wrap_req1", {31'd0, bus2.imem_req}, 1);
    chk("wrap_addr1", bus2.imem_addr, 32'h0000_0000);
    bus.imem_ack = 0; bus.dec_ready = 0;
    mpc = 32'h0000_3004; mcnt = 16'd1;
    for (int i = 0; i < 5; i++) begin
      chk("req_up", {31'd0, bus.imem_req}, 1);
      chk("req_addr", bus.imem_addr, mpc);
      for (int k = 0; k < vecs[i].ack_wait; k++) begin
        bus.imem_ack = 0;
        step;
        chk("wait_req", {31'd0, bus.imem_req}, 1);
        chk("wait_addr", bus.imem_addr, mpc);
        chk("wait_valid", {31'd0, bus.dec_valid}, 0);
      end
      bus.imem_ack = 1; bus.imem_rdata = vecs[i].rdata;
      sb.push_back('{mpc, vecs[i].rdata, vecs[i].op, vecs[i].fn});
      step;
      bus.imem_ack = 0; bus.imem_rdata = 32'hDEAD_BEEF;
      mpc = mpc + 32'd4;
      chk("hold_valid", {31'd0, bus.dec_valid}, 1);
      chk("hold_noreq", {31'd0, bus.imem_req}, 0);
      for (int k = 0; k < vecs[i].ready_wait; k++) begin
        bus.dec_ready = 0;
        step;
        chk("stall_valid", {31'd0, bus.dec_valid}, 1);
        chk("stall_noreq", {31'd0, bus.imem_req}, 0);
        chk("stall_instr", bus.dec_instr, vecs[i].rdata);
        chk("stall_cnt", {16'd0, bus.fetch_cnt}, {16'd0, mcnt});
      end
      bus.dec_ready = 1;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty actual=0 required=1");
      end else begin
        e = sb.pop_front();
        chk("sb_instr", bus.dec_instr, e.instr);
        chk("sb_pc", bus.dec_pc, e.pc);
        chk("sb_opcode", {26'd0, bus.dec_opcode}, {26'd0, e.op});
        chk("sb_funct", {26'd0, bus.dec_funct}, {26'd0, e.fn});
      end
      step;
      bus.dec_ready = 0;
      mcnt = mcnt + 16'd1;
      chk("acc_cnt", {16'd0, bus.fetch_cnt}, {16'd0, mcnt});
      chk("acc_valid", {31'd0, bus.dec_valid}, 0);
      chk("acc_req", {31'd0, bus.imem_req}, 1);
    end
    bus.imem_ack = 1; bus.imem_rdata = 32'hDEAD_BEEF; bus.redirect = 1; bus.redirect_pc = 32'h0000_3043;
    step;
    bus.imem_ack = 0; bus.redirect = 0;
    chk("rdq_valid", {31'd0, bus.dec_valid}, 0);
    chk("rdq_req", {31'd0, bus.imem_req}, 1);
    chk("rdq_addr", bus.imem_addr, 32'h0000_3040);
    chk("rdq_instr", bus.dec_instr, 32'h0000_0000);
    bus.imem_ack = 1; bus.imem_rdata = 32'h1111_1111;
    step;
    bus.imem_ack = 0;
    chk("rdh_valid0", {31'd0, bus.dec_valid}, 1);
    chk("rdh_pc0", bus.dec_pc, 32'h0000_3040);
    bus.redirect = 1; bus.redirect_pc = 32'h0000_5001; bus.dec_ready = 1;
    step;
    bus.redirect = 0; bus.dec_ready = 0;
    mcnt = mcnt + 16'd1;
    chk("rdh_valid", {31'd0, bus.dec_valid}, 0);
    chk("rdh_addr", bus.imem_addr, 32'h0000_5000);
    chk("rdh_cnt", {16'd0, bus.fetch_cnt}, {16'd0, mcnt});
    bus.imem_ack = 1; bus.imem_rdata = 32'h2222_2222;
    step;
    bus.imem_ack = 0;
    bus.redirect = 1; bus.redirect_pc = 32'h0000_6002;
    step;
    bus.redirect = 0;
    chk("rdn_valid", {31'd0, bus.dec_valid}, 0);
    chk("rdn_addr", bus.imem_addr, 32'h0000_6000);
    chk("rdn_cnt", {16'd0, bus.fetch_cnt}, {16'd0, mcnt});
    bus.imem_ack = 1; bus.imem_rdata = 32'h3333_3333;
    step;
    bus.imem_ack = 0;
    chk("mr_valid0", {31'd0, bus.dec_valid}, 1);
    #3 rst_n = 0;
    #1;
    chk("mr_valid", {31'd0, bus.dec_valid}, 0);
    chk("mr_cnt", {16'd0, bus.fetch_cnt}, 0);
    chk("mr_req", {31'd0, bus.imem_req}, 0);
    chk("mr_addr", bus.imem_addr, 32'h0000_3000);
    chk("mr_instr", bus.dec_instr, 0);
    @(negedge clk) rst_n = 1;
    step;
    chk("mr_refetch_req", {31'd0, bus.imem_req}, 1);
    chk("mr_refetch_addr", bus.imem_addr, 32'h0000_3000);
    rst_n = 0;
    #2;
    bus.redirect = 1; bus.redirect_pc = 32'h0000_7000;
    @(negedge clk) rst_n = 1;
    step;
    bus.redirect = 0;
    chk("idle_rd_req", {31'd0, bus.imem_req}, 1);
    chk("idle_rd_addr", bus.imem_addr, 32'h0000_7000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
